// File: rtl/fetch_inst_splitter_pkg.sv
// fetch_inst_splitter_pkg: shared widths, fetch-packet slot offsets and split-state encodings
package fetch_inst_splitter_pkg;
  localparam int ILEN = 32;
  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 32;
  typedef enum logic {ST_LO = 1'b0, ST_HI = 1'b1} split_st_e;
endpackage

// File: rtl/fetch_inst_splitter_if.sv
// fetch_inst_splitter_if: fetch-FIFO side and decode side handshake bundle
interface fetch_inst_splitter_if import fetch_inst_splitter_pkg::*; #(
  parameter int XLEN = 64
);
  logic [2*ILEN-1:0] in_data;
  logic [XLEN-1:0]   in_pc;
  logic              in_fault;
  logic              in_valid;
  logic              in_ready;
  logic [ILEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_pc;
  logic              out_fault;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output in_data, in_pc, in_fault, in_valid, out_ready,
    input  in_ready, out_instr, out_pc, out_fault, out_valid
  );
  modport slave (
    input  in_data, in_pc, in_fault, in_valid, out_ready,
    output in_ready, out_instr, out_pc, out_fault, out_valid
  );
endinterface

// File: rtl/fetch_inst_splitter_perf_counter.sv
// perf_counter: width-parameterised wrapping event counter with enable
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count enabled cycles, wrapping naturally at 2^W
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_inst_splitter.sv
// fetch_inst_splitter: splits 2-slot fetch packets into one registered instruction per cycle; FETCH_SPLIT_PERF_EN adds perf counters
module fetch_inst_splitter import fetch_inst_splitter_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  fetch_inst_splitter_if.slave bus
`ifdef FETCH_SPLIT_PERF_EN
  ,
  output logic [31:0]         perf_bubble_cnt_o,
  output logic [31:0]         perf_inst_cnt_o
`endif
);
  split_st_e       st_q, st_d;
  logic            out_valid_q, out_valid_d;
  logic            out_fault_q, out_fault_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            half, load;
  // once the lower slot is out, the upper slot is next regardless of the packet PC
  assign half = (st_q == ST_HI) || bus.in_pc[2];
  assign load = !rst && bus.in_valid && !flush_i && (!out_valid_q || bus.out_ready);
  assign bus.in_ready  = load && (half || bus.in_fault);
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_fault = out_fault_q;
  // next split state and output register contents
  always_comb begin
    st_d        = st_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_fault_d = out_fault_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      st_d        = ST_LO;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_fault_d = bus.in_fault;
      out_instr_d = bus.in_fault ? '0 : half ? bus.in_data[SLOT1_LSB +: ILEN] : bus.in_data[SLOT0_LSB +: ILEN];
      out_pc_d    = bus.in_fault ? bus.in_pc : {bus.in_pc[XLEN-1:3], half, 2'b00};
      st_d        = (bus.in_fault || half) ? ST_LO : ST_HI;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_LO;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_fault_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_fault_q <= out_fault_d;
    end
  end
`ifdef FETCH_SPLIT_PERF_EN
  perf_counter #(.W(32)) u_bubble (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.out_ready && !out_valid_q && !flush_i),
    .cnt_o (perf_bubble_cnt_o)
  );
  perf_counter #(.W(32)) u_inst (
    .clk   (clk),
    .rst   (rst),
    .en_i  (out_valid_q && bus.out_ready),
    .cnt_o (perf_inst_cnt_o)
  );
`endif
endmodule

// File: doc/fetch_inst_splitter.md
Name: fetch_inst_splitter

Overview:
- Consumes 64-bit fetch packets (two 32-bit instruction slots plus PC and fault flag) from the fetch-response 2-deep FWFT FIFO.
- Emits one instruction per cycle to decode.
- Handles a misaligned entry PC (pc[2]=1 skips the lower slot), access faults and pipeline flush.
- Output is fully registered so decode sees flop outputs only.

Parameters:
- XLEN, 64, PC width in bits; must be at least 3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline redirect; drops held output and split state
- in_data  in  64  fetch packet; [31:0] is the slot at pc[2]=0, [63:32] is the slot at pc[2]=1
- in_pc  in  XLEN  PC of the first valid slot in the packet
- in_fault  in  1  packet carries an access fault
- in_valid  in  1  packet available (FIFO b_valid)
- in_ready  out  1  packet fully consumed this cycle (FIFO b_ready)
- out_instr  out  32  instruction
- out_pc  out  XLEN  instruction PC
- out_fault  out  1  instruction carries an access fault
- out_valid  out  1  output holds an instruction
- out_ready  in  1  decode accepts the output

Behaviour:
- Registers: out_valid/out_instr/out_pc/out_fault; split state st ∈ {LO, HI}.
- Reset: out_valid=0, out_instr=0, out_pc=0, out_fault=0, st=LO. in_ready is 0 during reset.
- Slot select: half = (st==HI) ? 1 : in_pc[2].
- load = in_valid && !flush && (!out_valid || out_ready).
- On load:
  - out_instr = in_data[32*half +: 32]
  - out_pc = {in_pc[XLEN-1:3], half, 2'b00}
  - out_fault = in_fault
  - out_valid = 1
- in_ready = load && (half==1 || in_fault). Combinational from out_ready; this is allowed because the FIFO's b_ready input is not registered.
- State transitions on load:
  - Fault packet: emits one entry with out_instr=0 and out_pc=in_pc; the whole packet is consumed; st stays/returns LO.
  - half==0, no fault: st LO→HI; packet stays at FIFO head.
  - half==1, no fault: st→LO; packet popped.
- No load and out_ready=1: out_valid←0; data registers hold their values.
- No load and out_valid=1 and out_ready=0: all output registers hold.
- Throughput: 1 instruction/cycle; aligned packet takes 2 cycles, pc[2]=1 packet takes 1 cycle. Latency in→out is 1 cycle.
- Flush (has priority over everything):
  - Next cycle: out_valid=0, st=LO.
  - in_ready=0 during the flush cycle; the FIFO is cleared by the same redirect.
  - The packet at the FIFO head after the flush is treated as new: st=LO, so half comes from its in_pc.
- in_valid dropping while st=HI (not legal from the FWFT FIFO): st holds HI until the next packet; the bench flags it.
- Simultaneous flush and rst: rst wins; same end state.

Optional Feature:
- Macro FETCH_SPLIT_PERF_EN.
- Defined:
  - Adds output perf_bubble_cnt [31:0]: counts cycles with out_ready=1 && out_valid=0 && !flush; wraps at 2^32; reset 0.
  - Adds output perf_inst_cnt [31:0]: counts out_valid && out_ready handshakes; wraps at 2^32; reset 0.
- Undefined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Shared package:
  - localparam ILEN=32
  - fetch-packet field offsets (SLOT0_LSB=0, SLOT1_LSB=32)
  - split-state encodings ST_LO=1'b0, ST_HI=1'b1
- Single module; the output register is inline.
- Optional sub-module perf_counter (width-parameterised wrapping counter with enable), reusable elsewhere.

Test Plan:
- Aligned stream. Packets pc=0x1000 data=0xBBBBBBBB_AAAAAAAA, then pc=0x1008, out_ready=1.
  - Outputs: (0x1000,AAAAAAAA), (0x1004,BBBBBBBB), (0x1008,…) back-to-back.
  - in_ready pulses only on the second slot.
- Misaligned entry. pc=0x2004 data=0x22222222_11111111.
  - Single output (0x2004,22222222); in_ready=1 the same cycle; st stays LO.
- Backpressure. out_ready=0 for 5 cycles mid-packet.
  - out_* stable, in_ready=0, st=HI held.
  - On release, the next slot emits with PC +4.
- Fault. in_fault=1 pc=0x3000.
  - One output with out_fault=1, instr=0, pc=0x3000; packet popped after 1 cycle.
- Flush mid-packet. Flush while st=HI and out_valid=1.
  - Next cycle out_valid=0, st=LO.
  - New packet pc=0x4004 emits (0x4004, upper slot).
- Reset mid-stream. rst with out_valid=1.
  - Next cycle all outputs 0, in_ready=0.
  - With FETCH_SPLIT_PERF_EN defined, both counters read 0.
